wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Y86-64 architectural register file: the receiving end of the writeback stage.
//   Takes the W-stage write pair (dstE/valE, dstM/valM) and status. Serves decode's two combinational read ports.
//   Latches the machine-halt condition and counts retired instructions for the bench and controller.
// PARAMETERS
//   DATA_W  64     register width
//   CNT_W   32     retired-instruction counter width
//   RNONE   4'hF   "no register" id; reads return 0, writes ignored
// PORTS
//   clk_i          in   1       clock, rising edge
//   rst_n_i        in   1       asynchronous reset, active low
//   stall_i        in   1       W stall from controller; 1 = suppress all writes and count this cycle
//   W_stat_i       in   3       W status: SAOK=1 SHLT=2 SADR=3 SINS=4 (define.v)
//   W_icode_i      in   4       W icode; INOP=1 marks bubble/nop
//   W_dstE_i       in   4       E-port destination
//   W_valE_i       in   DATA_W  E-port data
//   W_dstM_i       in   4       M-port destination
//   W_valM_i       in   DATA_W  M-port data
//   d_srcA_i       in   4       decode read address A
//   d_srcB_i       in   4       decode read address B
//   d_rvalA_o      out  DATA_W  read data A
//   d_rvalB_o      out  DATA_W  read data B
//   dbg_addr_i     in   4       debug read address
//   dbg_data_o     out  DATA_W  debug read data, same rules as read ports
//   halted_o       out  1       sticky: non-AOK status reached writeback
//   retired_o      out  CNT_W   retired non-NOP instruction count
// BEHAVIOUR
//   - Storage: 15 regs, ids 0..14; id RNONE has no storage.
//   - Reset (async, rst_n_i=0): all regs 0, halted_o=0, retired_o=0. Reset mid-run clears immediately.
//   - State machine, 2 states:
//     RUN    -> HALTED on a rising edge with stall_i=0 and W_stat_i != SAOK.
//     HALTED -> RUN only via reset.
//   - Write enable, per port: we = ~stall_i & ~halted_o & (W_stat_i==SAOK) & (dst != RNONE).
//     The faulting/halting instruction itself writes nothing.
//   - Writes land on the rising edge. Write latency 1: the value is visible on reads from the next cycle.
//   - Dual write, same id (dstE==dstM, e.g. popq %rsp): valM wins, valE discarded.
//   - Reads are combinational. src==RNONE -> 0. Bypass rules are under CONFIGURATION.
//   - retired_o increments by 1 per edge when:
//     stall_i=0 & halted_o=0 & W_stat_i==SAOK & W_icode_i!=INOP.
//     Wraps modulo 2^CNT_W, no saturation.
//   - stall_i=1 holds all state, including the HALTED transition, which is deferred until stall drops.
//   - Unknown stat codes (0,5..7) are treated as non-AOK and halt.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - Each read port returns the pending write data when src matches an enabled write this cycle.
//     - M-port priority over E-port, same as the write rule.
//     - Lets decode drop its W-stage forwarding.
//   REGFILE_BYPASS_EN undefined:
//     - Reads return stored contents only.
//     - Same-cycle write data is visible from the next cycle.
//     - Decode's W forwarding is required.
// TESTING
//   1 reset: pulse rst_n_i low mid-cycle after writes -> all reads 0, halted_o=0, retired_o=0 immediately.
//   2 write/read: dstE=2 valE=0x1234, AOK, icode=IRRMOVQ; next cycle srcA=2 -> 0x1234; retired_o=1.
//     With BYPASS: the same-cycle read already returns 0x1234.
//   3 conflict: dstE=dstM=4, valE=0x10, valM=0x20 -> reg4=0x20.
//     RNONE: dstE=RNONE, valE=0x99 -> no reg changes; srcA=RNONE reads 0.
//   4 stall: stall_i=1 with dstE=3 valE=0x55, AOK -> reg3 and retired_o unchanged.
//     Drop stall -> reg3=0x55, retired_o+1.
//   5 halt: W_stat=SHLT with dstE=1 valE=7 -> reg1 unchanged, halted_o=1.
//     Then AOK writes to reg1 -> ignored and retired_o frozen until reset.
//   6 counting/wrap: INOP bubbles, AOK -> retired_o unchanged.
//     With CNT_W=4, 16 AOK non-NOP retirements from 0 -> retired_o=0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Writeback/decode bus for wb_regfile: W-stage write pair, status, decode and debug reads,
// plus halt/retire status. Master drives the W stage, slave is the register file.
interface wb_regfile_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
);
  logic              stall_i;
  logic [2:0]        W_stat_i;
  logic [3:0]        W_icode_i;
  logic [3:0]        W_dstE_i;
  logic [DATA_W-1:0] W_valE_i;
  logic [3:0]        W_dstM_i;
  logic [DATA_W-1:0] W_valM_i;
  logic [3:0]        d_srcA_i;
  logic [3:0]        d_srcB_i;
  logic [DATA_W-1:0] d_rvalA_o;
  logic [DATA_W-1:0] d_rvalB_o;
  logic [3:0]        dbg_addr_i;
  logic [DATA_W-1:0] dbg_data_o;
  logic              halted_o;
  logic [CNT_W-1:0]  retired_o;

  modport master (
    output stall_i, W_stat_i, W_icode_i, W_dstE_i, W_valE_i, W_dstM_i, W_valM_i,
    output d_srcA_i, d_srcB_i, dbg_addr_i,
    input  d_rvalA_o, d_rvalB_o, dbg_data_o, halted_o, retired_o
  );

  modport slave (
    input  stall_i, W_stat_i, W_icode_i, W_dstE_i, W_valE_i, W_dstM_i, W_valM_i,
    input  d_srcA_i, d_srcB_i, dbg_addr_i,
    output d_rvalA_o, d_rvalB_o, dbg_data_o, halted_o, retired_o
  );
endinterface

// File: rtl/wb_regfile.sv
// Y86-64 architectural register file at the writeback stage, with sticky halt and retire counter.
// Optional macro REGFILE_BYPASS_EN: read ports return same-cycle write data (M-port first).
module wb_regfile #(
  parameter int         DATA_W = 64,
  parameter int         CNT_W  = 32,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  wb_regfile_if.slave bus
);

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [3:0] INOP = 4'h1;

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_retired;
  logic [DATA_W-1:0] w_rf [16];

  logic w_aok;
  logic w_commit;
  logic w_we_e;
  logic w_we_m;

  // The halting instruction itself never commits: commit requires AOK status.
  assign w_aok    = (bus.W_stat_i == SAOK);
  assign w_commit = ~bus.stall_i & (r_state == ST_RUN) & w_aok;
  assign w_we_e   = w_commit & (bus.W_dstE_i != RNONE);
  assign w_we_m   = w_commit & (bus.W_dstM_i != RNONE);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg
      if (4'(gi) == RNONE) begin : g_none
        assign w_rf[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] r_reg;
        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            r_reg <= '0;
          end else if (w_we_m && bus.W_dstM_i == 4'(gi)) begin
            r_reg <= bus.W_valM_i;
          end else if (w_we_e && bus.W_dstE_i == 4'(gi)) begin
            r_reg <= bus.W_valE_i;
          end
        end
        assign w_rf[gi] = r_reg;
      end
    end
  endgenerate

  function automatic logic [DATA_W-1:0] rd_port(input logic [3:0] src);
    logic [DATA_W-1:0] val;
    val = w_rf[src];
`ifdef REGFILE_BYPASS_EN
    if (src != RNONE) begin
      if (w_we_m && bus.W_dstM_i == src)
        val = bus.W_valM_i;
      else if (w_we_e && bus.W_dstE_i == src)
        val = bus.W_valE_i;
    end
`endif
    return val;
  endfunction

  logic [DATA_W-1:0] w_rval_a;
  logic [DATA_W-1:0] w_rval_b;
  logic [DATA_W-1:0] w_dbg;

  always_comb begin
    w_rval_a = rd_port(bus.d_srcA_i);
    w_rval_b = rd_port(bus.d_srcB_i);
    w_dbg    = rd_port(bus.dbg_addr_i);
  end

  assign bus.d_rvalA_o  = w_rval_a;
  assign bus.d_rvalB_o  = w_rval_b;
  assign bus.dbg_data_o = w_dbg;

  // Halt is deferred while stalled; unknown status codes halt just like SHLT/SADR/SINS.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_RUN;
      r_retired <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!bus.stall_i && !w_aok)
            r_state <= ST_HALTED;
          if (w_commit && bus.W_icode_i != INOP)
            r_retired <= r_retired + 1'b1;
        end
        default: r_state <= ST_HALTED;
      endcase
    end
  end

  assign bus.halted_o  = (r_state == ST_HALTED);
  assign bus.retired_o = r_retired;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: a default instance plus a CNT_W=4 twin for wrap.
module tb_wb_regfile;
  localparam logic [2:0] SAOK = 3'd1, SHLT = 3'd2;
  localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3,
                         IOPQ = 4'h6, IPOPQ = 4'hB, RNONE = 4'hF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(64), .CNT_W(32)) bus ();
  wb_regfile_if #(.DATA_W(64), .CNT_W(4))  bus4 ();

  wb_regfile #(.DATA_W(64), .CNT_W(32)) u_dut  (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
  wb_regfile #(.DATA_W(64), .CNT_W(4))  u_dut4 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus4));

  assign bus4.stall_i    = bus.stall_i;
  assign bus4.W_stat_i   = bus.W_stat_i;
  assign bus4.W_icode_i  = bus.W_icode_i;
  assign bus4.W_dstE_i   = bus.W_dstE_i;
  assign bus4.W_valE_i   = bus.W_valE_i;
  assign bus4.W_dstM_i   = bus.W_dstM_i;
  assign bus4.W_valM_i   = bus.W_valM_i;
  assign bus4.d_srcA_i   = bus.d_srcA_i;
  assign bus4.d_srcB_i   = bus.d_srcB_i;
  assign bus4.dbg_addr_i = bus.dbg_addr_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic drive(input logic stall, input logic [2:0] stat, input logic [3:0] icode,
                       input logic [3:0] dst_e, input logic [63:0] val_e,
                       input logic [3:0] dst_m, input logic [63:0] val_m);
    bus.stall_i   = stall;
    bus.W_stat_i  = stat;
    bus.W_icode_i = icode;
    bus.W_dstE_i  = dst_e;
    bus.W_valE_i  = val_e;
    bus.W_dstM_i  = dst_m;
    bus.W_valM_i  = val_m;
  endtask

  task automatic idle();
    drive(1'b0, SAOK, INOP, RNONE, 64'h0, RNONE, 64'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_dbg(input logic [3:0] addr, input string tag, input logic [63:0] exp);
    bus.dbg_addr_i = addr;
    #1;
    check_eq(tag, bus.dbg_data_o, exp);
  endtask

  initial begin
    idle();
    bus.d_srcA_i = 4'd0;
    bus.d_srcB_i = 4'd0;
    bus.dbg_addr_i = 4'd0;
    step();
    check_eq("rst_rvalA", bus.d_rvalA_o, 64'h0);
    check_eq("rst_halted", {63'h0, bus.halted_o}, 64'h0);
    check_eq("rst_retired", {32'h0, bus.retired_o}, 64'h0);
    rst_n = 1'b1;
    step();

    // Simple write, latency 1 (or same cycle with bypass)
    drive(1'b0, SAOK, IRRMOVQ, 4'd2, 64'h1234, RNONE, 64'h0);
    bus.d_srcA_i = 4'd2;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("same_cycle_rd", bus.d_rvalA_o, 64'h1234);
`else
    check_eq("same_cycle_rd", bus.d_rvalA_o, 64'h0);
`endif
    step();
    idle();
    #1;
    check_eq("wr_rd_reg2", bus.d_rvalA_o, 64'h1234);
    check_eq("retired_1", {32'h0, bus.retired_o}, 64'd1);

    // Same-id dual write: M wins
    drive(1'b0, SAOK, IPOPQ, 4'd4, 64'h10, 4'd4, 64'h20);
    step();
    idle();
    bus.d_srcB_i = 4'd4;
    #1;
    check_eq("conflict_reg4", bus.d_rvalB_o, 64'h20);

    // RNONE write ignored, RNONE read is 0
    drive(1'b0, SAOK, IIRMOVQ, RNONE, 64'h99, RNONE, 64'h0);
    step();
    idle();
    bus.d_srcA_i = RNONE;
    #1;
    check_eq("rnone_rdA", bus.d_rvalA_o, 64'h0);
    rd_dbg(4'd2, "rnone_keep_reg2", 64'h1234);
    rd_dbg(4'd4, "rnone_keep_reg4", 64'h20);
    rd_dbg(RNONE, "rnone_dbg", 64'h0);
    check_eq("retired_3", {32'h0, bus.retired_o}, 64'd3);

    // Distinct E/M destinations both land
    drive(1'b0, SAOK, IPOPQ, 4'd6, 64'h66, 4'd7, 64'h70);
    step();
    idle();
    rd_dbg(4'd6, "dual_reg6", 64'h66);
    rd_dbg(4'd7, "dual_reg7", 64'h70);

    // Stall holds everything
    drive(1'b1, SAOK, IOPQ, 4'd3, 64'h55, RNONE, 64'h0);
    step();
    step();
    rd_dbg(4'd3, "stall_reg3", 64'h0);
    check_eq("stall_retired", {32'h0, bus.retired_o}, 64'd4);
    bus.stall_i = 1'b0;
    step();
    idle();
    rd_dbg(4'd3, "unstall_reg3", 64'h55);
    check_eq("unstall_retired", {32'h0, bus.retired_o}, 64'd5);

    // Bubbles do not count
    step();
    step();
    step();
    check_eq("bubble_retired", {32'h0, bus.retired_o}, 64'd5);

    // 11 more retirements: 16 total, the 4-bit counter wraps to 0
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, SAOK, IOPQ, 4'd9, 64'(i), RNONE, 64'h0);
      step();
    end
    idle();
    #1;
    check_eq("count_16", {32'h0, bus.retired_o}, 64'd16);
    check_eq("wrap_cnt4", {60'h0, bus4.retired_o}, 64'd0);
    rd_dbg(4'd9, "last_reg9", 64'd10);

    // Halt under stall is deferred
    drive(1'b1, SHLT, IHALT, 4'd1, 64'h7, RNONE, 64'h0);
    step();
    check_eq("halt_deferred", {63'h0, bus.halted_o}, 64'h0);
    bus.stall_i = 1'b0;
    step();
    check_eq("halt_set", {63'h0, bus.halted_o}, 64'h1);
    rd_dbg(4'd1, "halt_reg1", 64'h0);
    check_eq("halt_retired", {32'h0, bus.retired_o}, 64'd16);
    drive(1'b0, SAOK, IRRMOVQ, 4'd1, 64'h9, RNONE, 64'h0);
    step();
    step();
    idle();
    rd_dbg(4'd1, "halted_reg1", 64'h0);
    check_eq("halted_retired", {32'h0, bus.retired_o}, 64'd16);
    check_eq("halt_sticky", {63'h0, bus.halted_o}, 64'h1);

    // Asynchronous reset mid-cycle clears at once
    #2;
    rst_n = 1'b0;
    #1;
    rd_dbg(4'd2, "arst_reg2", 64'h0);
    check_eq("arst_halted", {63'h0, bus.halted_o}, 64'h0);
    check_eq("arst_retired", {32'h0, bus.retired_o}, 64'd0);
    step();
    rst_n = 1'b1;

    // Unknown status code halts and writes nothing
    drive(1'b0, 3'd0, IRRMOVQ, 4'd2, 64'h5, RNONE, 64'h0);
    step();
    idle();
    check_eq("stat0_halt", {63'h0, bus.halted_o}, 64'h1);
    rd_dbg(4'd2, "stat0_reg2", 64'h0);
    check_eq("stat0_retired", {32'h0, bus.retired_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
